pe_psum_accum: RTL and testbench

- Downstream stage of the convolution PE. It consumes the PE's 2N-bit partial-sum output stream.
- Accumulates CH consecutive partial sums (one per input channel/pass) into one output pixel.
- Saturates the result to OUT_W bits and buffers it in a small FIFO with a valid/ready handshake toward the output writer.

---
 rtl/pe_psum_accum.sv | 92 +++++++++
 tb/tb_pe_psum_accum.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_psum_accum.sv
// Partial-sum accumulator behind the convolution PE: sums CH beats per output pixel,
// saturates to OUT_W bits and queues results in a small valid/ready FIFO.
module pe_psum_accum #(
    parameter int N          = 8,
    parameter int CH         = 4,
    parameter int ACC_W      = 20,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*N-1:0]                psum_in,
    input  logic                          psum_valid,
    output logic                          psum_ready,
    input  logic                          flush,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_sat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CH):0]           beat_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = $clog2(CH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [ACC_W-1:0] OUT_MAX   = {ACC_W{1'b1}} >> (ACC_W - OUT_W);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             fifo_full;
    logic             accept;
    logic             last_beat;
    logic             flush_go;
    logic             push;
    logic             pop;
    logic             sum_sat;
    logic [OUT_W-1:0] sum_data;

    logic [OUT_W:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Control is derived from registered state only, so a same-cycle pop never frees a slot.
    always_comb begin
        fifo_full  = (fifo_level == FULL_LVL);
        psum_ready = (beat_cnt != LAST_BEAT) || !fifo_full;
        accept     = psum_valid && psum_ready;
        last_beat  = accept && (beat_cnt == LAST_BEAT);
        sum        = acc + (accept ? ACC_W'(psum_in) : '0);
        flush_go   = flush && ((beat_cnt != '0) || accept) && !fifo_full;
        push       = last_beat || flush_go;
        pop        = out_valid && out_ready;
        sum_sat    = (sum > OUT_MAX);
        sum_data   = sum_sat ? OUT_MAX[OUT_W-1:0] : sum[OUT_W-1:0];
        out_valid  = (fifo_level != '0);
        {out_sat, out_data} = out_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            beat_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                acc      <= '0;
                beat_cnt <= '0;
            end else if (accept) begin
                acc      <= sum;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
            else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the head is masked to zero while the level is 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {sum_sat, sum_data};
    end

endmodule

// File: tb/tb_pe_psum_accum.sv
// Bench for pe_psum_accum: directed vector table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_pe_psum_accum;

    localparam int N     = 8;
    localparam int CH    = 4;
    localparam int ACC_W = 20;
    localparam int OUT_W = 16;
    localparam int DEPTH = 4;
    localparam int OMAX  = (1 << OUT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] psum_in;
    logic        psum_valid;
    logic        psum_ready;
    logic        flush;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  beat_cnt;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_psum_accum #(.N(N), .CH(CH), .ACC_W(ACC_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .psum_in(psum_in), .psum_valid(psum_valid),
        .psum_ready(psum_ready), .flush(flush), .out_data(out_data), .out_sat(out_sat),
        .out_valid(out_valid), .out_ready(out_ready), .beat_cnt(beat_cnt), .fifo_level(fifo_level)
    );

    typedef struct {
        logic        v;
        logic [15:0] p;
        logic        f;
        logic        r;
        logic        ev;
        logic [15:0] ed;
        logic        es;
        logic [2:0]  ec;
        logic [2:0]  el;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    // Reference model: running integer sum, beat count and a queue of {sat, data}.
    int          m_acc;
    int          m_cnt;
    logic [16:0] m_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] p, input logic f, input logic r);
        psum_valid = v;
        psum_in    = p;
        flush      = f;
        out_ready  = r;
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [15:0] ed,
                              input logic es, input logic [2:0] ec, input logic [2:0] el,
                              input logic er);
        check({tag, ".out_valid"},  out_valid,  ev);
        check({tag, ".out_data"},   out_data,   ed);
        check({tag, ".out_sat"},    out_sat,    es);
        check({tag, ".beat_cnt"},   beat_cnt,   ec);
        check({tag, ".fifo_level"}, fifo_level, el);
        check({tag, ".psum_ready"}, psum_ready, er);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        repeat (n) step();
        reset = 1'b0;
        expect_out("reset", 1'b0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b1);
    endtask

    task automatic add_vec(input logic v, input logic [15:0] p, input logic f,
                           input logic ev, input logic [15:0] ed, input logic es,
                           input logic [2:0] ec, input logic [2:0] el);
        vec_t t;
        t = '{v: v, p: p, f: f, r: 1'b1, ev: ev, ed: ed, es: es, ec: ec, el: el, er: 1'b1};
        vecs.push_back(t);
    endtask

    function automatic logic [16:0] sat_of(input int x);
        logic [16:0] r;
        if (x > OMAX) r = {1'b1, 16'hFFFF};
        else          r = {1'b0, x[15:0]};
        return r;
    endfunction

    task automatic model_tick(input logic r, input logic v, input logic [15:0] p,
                              input logic f, input logic rdy);
        bit full;
        bit took;
        bit fin;
        bit fl;
        int t;
        if (r) begin
            m_acc = 0;
            m_cnt = 0;
            m_q.delete();
            return;
        end
        full = (m_q.size() == DEPTH);
        took = v && !(m_cnt == CH - 1 && full);
        t    = m_acc + (took ? int'(p) : 0);
        fin  = took && (m_cnt == CH - 1);
        fl   = f && (m_cnt != 0 || took) && !full;
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (fin || fl) begin
            m_q.push_back(sat_of(t));
            m_acc = 0;
            m_cnt = 0;
        end else if (took) begin
            m_acc = t;
            m_cnt++;
        end
    endtask

    task automatic feed_group(input logic [15:0] val, input logic rdy_last);
        for (int b = 0; b < CH; b++) begin
            drive(1'b1, val, 1'b0, (b == CH - 1) ? rdy_last : 1'b0);
            step();
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n_seen;
        int          seen_bad;
        logic [15:0] last_seen;

        reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0);

        // ---------------- directed vector table ----------------
        add_vec(1, 16'd1,    0, 0, 16'd0,    0, 3'd1, 3'd0);
        add_vec(1, 16'd2,    0, 0, 16'd0,    0, 3'd2, 3'd0);
        add_vec(1, 16'd3,    0, 0, 16'd0,    0, 3'd3, 3'd0);
        add_vec(1, 16'd4,    0, 1, 16'd10,   0, 3'd0, 3'd1);
        add_vec(0, 16'd0,    0, 0, 16'd0,    0, 3'd0, 3'd0);
        add_vec(1, 16'hFFFF, 0, 0, 16'd0,    0, 3'd1, 3'd0);
        add_vec(1, 16'hFFFF, 0, 0, 16'd0,    0, 3'd2, 3'd0);
        add_vec(1, 16'hFFFF, 0, 0, 16'd0,    0, 3'd3, 3'd0);
        add_vec(1, 16'hFFFF, 0, 1, 16'hFFFF, 1, 3'd0, 3'd1);
        add_vec(1, 16'd1,    0, 0, 16'd0,    0, 3'd1, 3'd0);
        add_vec(1, 16'd1,    0, 0, 16'd0,    0, 3'd2, 3'd0);
        add_vec(1, 16'd1,    0, 0, 16'd0,    0, 3'd3, 3'd0);
        add_vec(1, 16'd1,    0, 1, 16'd4,    0, 3'd0, 3'd1);
        add_vec(0, 16'd0,    0, 0, 16'd0,    0, 3'd0, 3'd0);
        add_vec(1, 16'd7,    0, 0, 16'd0,    0, 3'd1, 3'd0);
        add_vec(1, 16'd8,    0, 0, 16'd0,    0, 3'd2, 3'd0);
        add_vec(0, 16'd0,    1, 1, 16'd15,   0, 3'd0, 3'd1);
        add_vec(0, 16'd0,    1, 0, 16'd0,    0, 3'd0, 3'd0);
        add_vec(0, 16'd0,    1, 0, 16'd0,    0, 3'd0, 3'd0);
        add_vec(1, 16'd5,    0, 0, 16'd0,    0, 3'd1, 3'd0);
        add_vec(1, 16'd6,    1, 1, 16'd11,   0, 3'd0, 3'd1);
        add_vec(0, 16'd0,    0, 0, 16'd0,    0, 3'd0, 3'd0);
        add_vec(1, 16'd1,    0, 0, 16'd0,    0, 3'd1, 3'd0);
        add_vec(1, 16'd1,    0, 0, 16'd0,    0, 3'd2, 3'd0);
        add_vec(1, 16'd1,    0, 0, 16'd0,    0, 3'd3, 3'd0);
        add_vec(1, 16'd2,    1, 1, 16'd5,    0, 3'd0, 3'd1);
        add_vec(0, 16'd0,    0, 0, 16'd0,    0, 3'd0, 3'd0);
        add_vec(1, 16'hFFFF, 0, 0, 16'd0,    0, 3'd1, 3'd0);
        add_vec(1, 16'd0,    0, 0, 16'd0,    0, 3'd2, 3'd0);
        add_vec(1, 16'd0,    0, 0, 16'd0,    0, 3'd3, 3'd0);
        add_vec(1, 16'd0,    0, 1, 16'hFFFF, 0, 3'd0, 3'd1);
        add_vec(1, 16'hFFFF, 0, 0, 16'd0,    0, 3'd1, 3'd0);
        add_vec(1, 16'd1,    0, 0, 16'd0,    0, 3'd2, 3'd0);
        add_vec(1, 16'd0,    0, 0, 16'd0,    0, 3'd3, 3'd0);
        add_vec(1, 16'd0,    0, 1, 16'hFFFF, 1, 3'd0, 3'd1);
        add_vec(0, 16'd0,    0, 0, 16'd0,    0, 3'd0, 3'd0);

        do_reset(2);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].p, vecs[i].f, vecs[i].r);
            step();
            expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].es,
                       vecs[i].ec, vecs[i].el, vecs[i].er);
        end

        // ---------------- backpressure: full FIFO stalls only the final beat ----------------
        do_reset(1);
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < CH; b++) begin
                check("bp.ready_early", psum_ready, 1'b1);
                drive(1'b1, 16'd1, 1'b0, 1'b0);
                step();
            end
        end
        expect_out("bp.full", 1'b1, 16'd4, 1'b0, 3'd0, 3'd4, 1'b1);
        for (int b = 0; b < CH - 1; b++) begin
            check("bp.ready_g5", psum_ready, 1'b1);
            drive(1'b1, 16'd1, 1'b0, 1'b0);
            step();
        end
        expect_out("bp.stall", 1'b1, 16'd4, 1'b0, 3'd3, 3'd4, 1'b0);
        drive(1'b1, 16'd1, 1'b0, 1'b0);
        step();
        expect_out("bp.held", 1'b1, 16'd4, 1'b0, 3'd3, 3'd4, 1'b0);
        drive(1'b1, 16'd1, 1'b0, 1'b1);
        step();
        expect_out("bp.pop", 1'b1, 16'd4, 1'b0, 3'd3, 3'd3, 1'b1);
        drive(1'b1, 16'd1, 1'b0, 1'b0);
        step();
        expect_out("bp.refill", 1'b1, 16'd4, 1'b0, 3'd0, 3'd4, 1'b1);
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            check("bp.drain_data", out_data, 16'd4);
            step();
            check("bp.drain_level", fifo_level, 3'(DEPTH - 1 - k));
        end
        check("bp.drained_valid", out_valid, 1'b0);

        // ---------------- simultaneous push and pop ----------------
        do_reset(1);
        feed_group(16'd1, 1'b0);
        feed_group(16'd2, 1'b0);
        check("pp.level2", fifo_level, 3'd2);
        check("pp.head4", out_data, 16'd4);
        feed_group(16'd3, 1'b1);
        check("pp.level_kept", fifo_level, 3'd2);
        check("pp.head8", out_data, 16'd8);
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        step();
        check("pp.head12", out_data, 16'd12);
        check("pp.level1", fifo_level, 3'd1);
        step();
        expect_out("pp.empty", 1'b0, 16'd0, 1'b0, 3'd0, 3'd0, 1'b1);

        // ---------------- reset in the middle of a group ----------------
        do_reset(1);
        drive(1'b1, 16'd5, 1'b0, 1'b1);
        step();
        step();
        check("rm.cnt2", beat_cnt, 3'd2);
        reset = 1'b1;
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        expect_out("rm.after_reset", 1'b0, 16'd0, 1'b0, 3'd0, 3'd0, 1'b1);
        n_seen    = 0;
        seen_bad  = 0;
        last_seen = '0;
        for (int c = 0; c < CH + 4; c++) begin
            drive(c < CH, 16'd1, 1'b0, 1'b1);
            step();
            if (out_valid) begin
                n_seen++;
                last_seen = out_data;
                if (out_data == 16'd10 || out_data == 16'd14) seen_bad++;
            end
        end
        check("rm.outputs_seen", n_seen, 1);
        check("rm.stale_seen", seen_bad, 0);
        check("rm.value", last_seen, 16'd4);

        // ---------------- randomized traffic against the reference model ----------------
        do_reset(1);
        model_tick(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        v;
            logic        f;
            logic        rdy;
            logic [15:0] p;
            logic [16:0] head;
            int          thr;
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       p = 16'hFFFF;
                1:       p = 16'($urandom_range(0, 15));
                default: p = 16'($urandom);
            endcase
            f   = ($urandom_range(0, 19) == 0);
            if (m_cnt == 0 && v) f = 1'b0;
            thr = ((i / 400) % 2 == 1) ? 8 : 2;
            rdy = ($urandom_range(0, 9) < thr);
            reset = r;
            drive(v, p, f, rdy);
            model_tick(r, v, p, f, rdy);
            step();
            head = (m_q.size() > 0) ? m_q[0] : 17'h0;
            expect_out($sformatf("rand%0d", i), m_q.size() != 0, head[15:0], head[16],
                       3'(m_cnt), 3'(m_q.size()),
                       !(m_cnt == CH - 1 && m_q.size() == DEPTH));
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
